// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: GF(2^8) xtime, state geometry and
// column/byte accessors for the 128-bit state layout (column 0 in the MSBs).
package aes_pkg;

    localparam logic [7:0] AES_POLY    = 8'h1B;
    localparam int         AES_STATE_W = 128;
    localparam int         AES_COL_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [AES_COL_W-1:0] get_col(input logic [AES_STATE_W-1:0] s,
                                                      input logic [1:0] c);
        return s[(AES_STATE_W-1) - AES_COL_W*int'(c) -: AES_COL_W];
    endfunction

    function automatic logic [AES_STATE_W-1:0] set_col(input logic [AES_STATE_W-1:0] s,
                                                        input logic [1:0] c,
                                                        input logic [AES_COL_W-1:0] v);
        logic [AES_STATE_W-1:0] r;
        r = s;
        r[(AES_STATE_W-1) - AES_COL_W*int'(c) -: AES_COL_W] = v;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [AES_COL_W-1:0] col,
                                            input logic [1:0] r);
        return col[(AES_COL_W-1) - 8*int'(r) -: 8];
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in the MSBs).
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_i,
    output logic [AES_COL_W-1:0] col_o
);

    logic [7:0] m9_s [4];
    logic [7:0] mb_s [4];
    logic [7:0] md_s [4];
    logic [7:0] me_s [4];

    // Per-byte multiples by 09/0B/0D/0E built from xtime powers.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            logic [7:0] a, x1, x2, x3;
            a  = get_byte(col_i, 2'(r));
            x1 = xtime(a);
            x2 = xtime(x1);
            x3 = xtime(x2);
            m9_s[r] = x3 ^ a;
            mb_s[r] = x3 ^ x1 ^ a;
            md_s[r] = x3 ^ x2 ^ a;
            me_s[r] = x3 ^ x2 ^ x1;
        end
    end

    // Row r combines a_r..a_(r+3) with the rotated coefficient vector.
    always_comb begin
        col_o = {AES_COL_W{1'b0}};
        for (int r = 0; r < 4; r++) begin
            col_o[(AES_COL_W-1) - 8*r -: 8] = me_s[2'(r)]     ^ mb_s[2'(r + 1)] ^
                                              md_s[2'(r + 2)] ^ m9_s[2'(r + 3)];
        end
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: captures a state, transforms COLS_PER_CYCLE columns
// per clock, then holds the result until downstream accepts it.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int         LAT      = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    imc_state_e             state_q, state_d;
    logic [1:0]             col_cnt_q, col_cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic                   out_valid_q, out_valid_d;
    logic [AES_STATE_W-1:0] out_state_q, out_state_d;

    logic [1:0]           col_idx_s [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] col_in_s  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] col_out_s [COLS_PER_CYCLE];
    logic                 accept_s;

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
            assign col_idx_s[k] = col_cnt_q + 2'(k);
            assign col_in_s[k]  = get_col(work_q, col_idx_s[k]);
            inv_mix_single_column u_col (
                .col_i (col_in_s[k]),
                .col_o (col_out_s[k])
            );
        end
    endgenerate

    // Ready is combinational so a DONE result and a new capture share one cycle.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

    // Next-state and datapath computation for all registers.
    always_comb begin
        logic [AES_STATE_W-1:0] t;
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        work_d      = work_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        t           = work_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    work_d    = in_state;
                    col_cnt_d = 2'd0;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    t = set_col(t, col_idx_s[k], col_out_s[k]);
                end
                work_d = t;
                // Counter saturates on the last group; the result is published here.
                if (col_cnt_q == LAST_GRP) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_state_d = t;
                end else begin
                    col_cnt_d   = col_cnt_q + CNT_STEP;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept_s) begin
                        work_d    = in_state;
                        col_cnt_d = 2'd0;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                col_cnt_d   = 2'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= 2'd0;
            work_q      <= {AES_STATE_W{1'b0}};
            out_valid_q <= 1'b0;
            out_state_q <= {AES_STATE_W{1'b0}};
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    // LAT only documents the BUSY length; the counter end-point realises it.
    logic unused_lat_s;
    assign unused_lat_s = (LAT == 0);

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq with COLS_PER_CYCLE = 1, 2, 4
// against a generic GF(2^8) matrix model of MixColumns / InvMixColumns.
module tb_inv_mix_columns_seq;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        in_valid;
    logic [2:0]        in_ready;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [127:0]      in_state [3];
    logic [2:0][127:0] out_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input int m);
        logic [7:0] p, aa;
        logic       hi;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (((m >> i) & 1) == 1) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1B;
        end
        return p;
    endfunction

    // Circulant matrix product per column; inv selects InvMixColumns coefficients.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
        logic [7:0]   b [16];
        int           cf [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) cf = '{14, 11, 13, 9};
        else     cf = '{2, 3, 1, 1};
        for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(b[4*c + (r + k) % 4], cf[k]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // One transaction on DUT d; lat counts edges from capture edge (=1) to out_valid.
    task automatic send(input int d, input logic [127:0] s, output logic [127:0] res, output int lat);
        int n;
        in_state[d]  = s;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 64) begin tick(); n++; end
        check("in_ready_wait", {127'd0, in_ready[d]}, 128'd1);
        tick();
        in_valid[d] = 1'b0;
        in_state[d] = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
        lat = 1;
        while (!out_valid[d] && lat < 64) begin tick(); lat++; end
        check("out_valid_wait", {127'd0, out_valid[d]}, 128'd1);
        res = out_state[d];
        tick();
    endtask

    localparam logic [127:0] V1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1E = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
    localparam logic [127:0] V2E = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

    initial begin
        logic [127:0] res, held, s, f;
        int           lat, t1, t2, n;

        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int d = 0; d < 3; d++) in_state[d] = 128'h0;
        #1;
        check("in_ready_in_reset", {125'd0, in_ready}, 128'd0);
        tick(); tick();
        check("reset_out_valid", {125'd0, out_valid}, 128'd0);
        for (int d = 0; d < 3; d++) check("reset_out_state", out_state[d], 128'h0);
        check("in_ready_during_reset", {125'd0, in_ready}, 128'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_idle", {125'd0, in_ready}, 128'd7);

        // Vectors 1 and 2 on every width, with latency LAT+1 edges.
        for (int d = 0; d < 3; d++) begin
            send(d, V1, res, lat);
            check("vec1", res, V1E);
            check("vec1_latency", 128'(lat), 128'(4 / (1 << d) + 1));
            send(d, V2, res, lat);
            check("vec2_col_order", res, V2E);
            check("model_vec1", mix_model(V1, 1'b1), V1E);
        end

        // Backpressure on the single-column engine.
        in_state[0]  = V2;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        tick();
        in_state[0] = V1;
        n = 0;
        while (!out_valid[0] && n < 64) begin tick(); n++; end
        held = out_state[0];
        check("bp_value", held, V2E);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_stable", out_state[0], held);
            check("bp_in_ready", {127'd0, in_ready[0]}, 128'd0);
            check("bp_valid", {127'd0, out_valid[0]}, 128'd1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("bp_release_valid", {127'd0, out_valid[0]}, 128'd0);
        check("bp_release_idle", {127'd0, in_ready[0]}, 128'd1);

        // Back-to-back with in_valid and out_ready held high.
        in_state[0] = V1;
        in_valid[0] = 1'b1;
        tick();
        in_state[0] = V2;
        n = 0;
        while (!out_valid[0] && n < 64) begin tick(); n++; end
        t1 = cyc;
        check("b2b_first", out_state[0], V1E);
        tick();
        in_valid[0] = 1'b0;
        check("b2b_drop", {127'd0, out_valid[0]}, 128'd0);
        n = 0;
        while (!out_valid[0] && n < 64) begin tick(); n++; end
        t2 = cyc;
        check("b2b_second", out_state[0], V2E);
        check("b2b_spacing", 128'(t2 - t1), 128'd5);
        tick();

        // Reset during BUSY cycle 2 discards the block.
        in_state[0] = V1;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready_forced", {127'd0, in_ready[0]}, 128'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", {127'd0, out_valid[0]}, 128'd0);
        check("rst_out_state", out_state[0], 128'h0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[0]) n++;
            tick();
        end
        check("rst_no_spurious", 128'(n), 128'd0);
        send(0, V2, res, lat);
        check("rst_recover", res, V2E);

        // Random round trip through the forward model.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                f = mix_model(s, 1'b0);
                send(d, f, res, lat);
                check("roundtrip", res, s);
                check("rand_vs_model", res, mix_model(f, 1'b1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
